ps2_scancode_tracker: RTL

Parametrised PS/2 scan-code decoder that sits between `PS2_Controller` and the display and game logic. It consumes the raw byte strobe (`received_data`/`received_data_en`) and resolves the set-2 `E0`/`F0` prefixes into 9-bit make/break events. It also keeps a newest-first history of the last `DEPTH` make codes and tracks the held state of `NUM_WATCH` configurable watched keys. It replaces the single-byte latch and the hard-wired key-match flag with a general key-state front end.

---
 rtl/ps2_scancode_tracker_pkg.sv | 34 +++
 rtl/ps2_scancode_tracker_if.sv | 21 ++
 rtl/ps2_prefix_fsm.sv | 117 +++++++++++
 rtl/ps2_scancode_tracker.sv | 105 ++++++++++
 4 files changed

// File: rtl/ps2_scancode_tracker_pkg.sv
// Shared types and byte constants for the PS/2 set-2 scan-code tracker.
// Defines the prefix FSM states, prefix/status bytes and the 9-bit code type.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GOT_E0   = 2'd1,
      ST_GOT_F0   = 2'd2,
      ST_GOT_E0F0 = 2'd3
   } ps2_state_t;

   typedef logic [8:0] ps2_code_t;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;
   localparam logic [7:0] PS2_AA = 8'hAA;
   localparam logic [7:0] PS2_FA = 8'hFA;
   localparam logic [7:0] PS2_FC = 8'hFC;
   localparam logic [7:0] PS2_EE = 8'hEE;
   localparam logic [7:0] PS2_FE = 8'hFE;
   localparam logic [7:0] PS2_00 = 8'h00;
   localparam logic [7:0] PS2_FF = 8'hFF;

   // Controller/keyboard status bytes that carry no key information in IDLE.
   function automatic logic is_status_byte(input logic [7:0] b);
      logic r;
      case (b)
         PS2_AA, PS2_FA, PS2_FC, PS2_EE, PS2_FE, PS2_00, PS2_FF: r = 1'b1;
         default:                                                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_scancode_tracker_if.sv
// Byte-strobe input and key-event output bundle of the scan-code tracker.
interface ps2_scancode_tracker_if;
   import ps2_pkg::*;

   logic [7:0] received_data;
   logic       received_data_en;
   logic       evt_valid;
   logic       evt_break;
   ps2_code_t  evt_code;

   modport master (
      output received_data, received_data_en,
      input  evt_valid, evt_break, evt_code
   );

   modport slave (
      input  received_data, received_data_en,
      output evt_valid, evt_break, evt_code
   );

endinterface

// File: rtl/ps2_prefix_fsm.sv
// E0/F0 prefix resolver with idle timeout; emits a combinational decode for
// the top level and the registered event/timeout outputs.
module ps2_prefix_fsm
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       clear,
   input  logic [7:0] rx_data,
   input  logic       rx_en,
   input  logic       suppress,
   output logic       dec_valid,
   output logic       dec_break,
   output ps2_code_t  dec_code,
   output logic       evt_valid,
   output logic       evt_break,
   output ps2_code_t  evt_code,
   output logic       seq_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ps2_state_t       state_r;
   ps2_state_t       next_state_s;
   logic [CNT_W-1:0] cnt_r;

   // Decode the current strobe against the prefix state.
   always_comb begin
      dec_valid    = 1'b0;
      dec_break    = 1'b0;
      dec_code     = {1'b0, rx_data};
      next_state_s = state_r;
      if (rx_en) begin
         case (state_r)
            ST_IDLE: begin
               if (rx_data == PS2_E0) begin
                  next_state_s = ST_GOT_E0;
               end else if (rx_data == PS2_F0) begin
                  next_state_s = ST_GOT_F0;
               end else if (is_status_byte(rx_data)) begin
                  next_state_s = ST_IDLE;
               end else begin
                  dec_valid = 1'b1;
               end
            end
            ST_GOT_E0: begin
               if (rx_data == PS2_F0) begin
                  next_state_s = ST_GOT_E0F0;
               end else if (rx_data == PS2_E0) begin
                  next_state_s = ST_GOT_E0;
               end else begin
                  dec_valid    = 1'b1;
                  dec_code     = {1'b1, rx_data};
                  next_state_s = ST_IDLE;
               end
            end
            ST_GOT_F0: begin
               dec_valid    = 1'b1;
               dec_break    = 1'b1;
               next_state_s = ST_IDLE;
            end
            ST_GOT_E0F0: begin
               dec_valid    = 1'b1;
               dec_break    = 1'b1;
               dec_code     = {1'b1, rx_data};
               next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   // State, timeout counter and registered event/timeout outputs.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         evt_valid   <= 1'b0;
         evt_break   <= 1'b0;
         evt_code    <= 9'h000;
         seq_timeout <= 1'b0;
      end else if (clear) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         evt_valid   <= 1'b0;
         seq_timeout <= 1'b0;
      end else begin
         evt_valid   <= dec_valid & ~suppress;
         seq_timeout <= 1'b0;
         if (dec_valid && !suppress) begin
            evt_break <= dec_break;
            evt_code  <= dec_code;
         end
         if (rx_en) begin
            // A strobe always wins over a coincident expiry.
            state_r <= next_state_s;
            cnt_r   <= '0;
         end else if (state_r != ST_IDLE) begin
            if (cnt_r == CNT_LAST) begin
               state_r     <= ST_IDLE;
               cnt_r       <= '0;
               seq_timeout <= 1'b1;
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_tracker.sv
// PS/2 set-2 key-state front end: make/break events, make history, watched-key
// held flags. Optional build macro PS2_TYPEMATIC_FILTER_EN drops repeats of held watched keys.
module ps2_scancode_tracker
   import ps2_pkg::*;
#(
   parameter int unsigned             DEPTH          = 4,
   parameter int unsigned             NUM_WATCH      = 2,
   parameter logic [NUM_WATCH*9-1:0]  WATCH_CODES    = {9'h01B, 9'h01D},
   parameter int unsigned             TIMEOUT_CYCLES = 100000
) (
   input  logic                         CLOCK_50,
   input  logic                         reset_n,
   input  logic                         clear,
   ps2_scancode_tracker_if.slave        bus,
   output logic [DEPTH*9-1:0]           hist_codes,
   output logic [$clog2(DEPTH+1)-1:0]   hist_count,
   output logic [NUM_WATCH-1:0]         watch_held,
   output logic                         any_watch_held,
   output logic                         seq_timeout
);

   localparam int unsigned HC_W = $clog2(DEPTH + 1);

   logic           dec_valid_s;
   logic           dec_break_s;
   ps2_code_t      dec_code_s;
   logic           suppress_s;
   logic           push_s;
   logic           evt_valid_s;
   logic           evt_break_s;
   ps2_code_t      evt_code_s;
   logic [NUM_WATCH-1:0] match_s;
   logic [NUM_WATCH-1:0] held_next_s;
   ps2_code_t      hist_r [DEPTH];

   ps2_prefix_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
      .CLOCK_50    (CLOCK_50),
      .reset_n     (reset_n),
      .clear       (clear),
      .rx_data     (bus.received_data),
      .rx_en       (bus.received_data_en),
      .suppress    (suppress_s),
      .dec_valid   (dec_valid_s),
      .dec_break   (dec_break_s),
      .dec_code    (dec_code_s),
      .evt_valid   (evt_valid_s),
      .evt_break   (evt_break_s),
      .evt_code    (evt_code_s),
      .seq_timeout (seq_timeout)
   );

   assign bus.evt_valid = evt_valid_s;
   assign bus.evt_break = evt_break_s;
   assign bus.evt_code  = evt_code_s;

   // Watch comparators, repeat filter and next held-flag vector.
   always_comb begin
      match_s     = '0;
      held_next_s = watch_held;
      for (int i = 0; i < int'(NUM_WATCH); i++) begin
         match_s[i] = (dec_code_s == WATCH_CODES[9*i +: 9]);
         if (dec_valid_s && match_s[i]) begin
            held_next_s[i] = ~dec_break_s;
         end else begin
            held_next_s[i] = watch_held[i];
         end
      end
`ifdef PS2_TYPEMATIC_FILTER_EN
      suppress_s = dec_valid_s & ~dec_break_s & (|(match_s & watch_held));
`else
      suppress_s = 1'b0;
`endif
      push_s = dec_valid_s & ~dec_break_s & ~suppress_s;
   end

   // History shift register, saturating count and held flags.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) hist_r[i] <= 9'h000;
         hist_count     <= '0;
         watch_held     <= '0;
         any_watch_held <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < int'(DEPTH); i++) hist_r[i] <= 9'h000;
         hist_count     <= '0;
         watch_held     <= '0;
         any_watch_held <= 1'b0;
      end else begin
         if (push_s) begin
            for (int i = 1; i < int'(DEPTH); i++) hist_r[i] <= hist_r[i-1];
            hist_r[0] <= dec_code_s;
            if (hist_count != HC_W'(DEPTH)) hist_count <= hist_count + HC_W'(1);
         end
         watch_held     <= held_next_s;
         any_watch_held <= |held_next_s;
      end
   end

   // Flatten history, newest entry in the low bits.
   always_comb begin
      hist_codes = '0;
      for (int i = 0; i < int'(DEPTH); i++) hist_codes[9*i +: 9] = hist_r[i];
   end

endmodule
